// File: rtl/conv_feed_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// conv_feed_ctrl
//
// Sequences one full feature-map convolution through a broadcast-weight PE
// array. For every tile the block clears the PE accumulators, streams
// NUM_CH*KERNEL_PIX (IFM word, weight byte) pairs out of the two buffers,
// waits for the PE pipeline to drain, and then holds ofm_valid until the
// downstream stage accepts the tile result.
//
// Ports
//   clk          : sole clock, rising edge
//   reset_n      : asynchronous active-low reset
//   start        : one-cycle request to convolve a full map (ignored while busy)
//   busy         : high from start acceptance through the done cycle
//   done         : one-cycle pulse after the last tile is handed off
//   ifm_rd_en    : IFM buffer read strobe
//   ifm_rd_addr  : IFM buffer word address
//   ifm_rd_data  : IFM word, valid the cycle after ifm_rd_en
//   wgt_rd_en    : weight buffer read strobe
//   wgt_rd_addr  : weight buffer byte address
//   wgt_rd_data  : weight byte, valid the cycle after wgt_rd_en
//   IFM          : registered operand bus to the PE array
//   Weight       : registered broadcast weight to the PE array
//   PE_restart   : accumulator clear, replicated to every PE
//   ofm_valid    : PE array output holds the result of tile tile_idx
//   ofm_ready    : downstream accepts the tile result
//   tile_idx     : index of the tile currently being processed
// -----------------------------------------------------------------------------
module conv_feed_ctrl #(
    parameter  int NUM_OF_PE  = 256,
    parameter  int KERNEL_PIX = 9,
    parameter  int NUM_CH     = 3,
    parameter  int NUM_TILES  = 4,
    parameter  int DRAIN_LAT  = 3,
    localparam int ADDR_W     = $clog2(NUM_TILES * NUM_CH * KERNEL_PIX),
    localparam int TILE_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   ifm_rd_en,
    output logic [ADDR_W-1:0]      ifm_rd_addr,
    input  logic [NUM_OF_PE*8-1:0] ifm_rd_data,
    output logic                   wgt_rd_en,
    output logic [ADDR_W-1:0]      wgt_rd_addr,
    input  logic [7:0]             wgt_rd_data,
    output logic [NUM_OF_PE*8-1:0] IFM,
    output logic [7:0]             Weight,
    output logic [NUM_OF_PE-1:0]   PE_restart,
    output logic                   ofm_valid,
    input  logic                   ofm_ready,
    output logic [TILE_W-1:0]      tile_idx
);

    // Steps per tile: one (channel, kernel pixel) pair per cycle.
    localparam int STEPS  = NUM_CH * KERNEL_PIX;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int DCNT_W = $clog2(DRAIN_LAT + 1) + 1;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
    localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);
    // DRAIN covers the operand register stage plus the PE latency.
    localparam logic [DCNT_W-1:0] DRAIN_END = DCNT_W'(DRAIN_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESTART,
        S_STREAM,
        S_DRAIN,
        S_WAIT_OFM,
        S_DONE
    } state_t;

    state_t              state;
    logic [STEP_W-1:0]   step;
    logic [DCNT_W-1:0]   drain_cnt;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_en;
    logic                pe_restart_q;
    logic                rd_valid;
    logic [ADDR_W-1:0]   tile_base;

    // Step s of tile t lives at t*STEPS + s, where s = ch*KERNEL_PIX + pix.
    // Within a tile the address therefore simply increments from tile_base.
    assign tile_base = ADDR_W'(tile_idx) * ADDR_W'(STEPS);

    // Both buffers share one address and one strobe.
    assign ifm_rd_en   = rd_en;
    assign wgt_rd_en   = rd_en;
    assign ifm_rd_addr = rd_addr;
    assign wgt_rd_addr = rd_addr;

    assign PE_restart  = {NUM_OF_PE{pe_restart_q}};

    // -------------------------------------------------------------------------
    // Control FSM. All outputs are registered and set on the transition into
    // the state that owns them, so they line up exactly with the state cycle.
    // -------------------------------------------------------------------------
    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            ofm_valid    <= 1'b0;
            pe_restart_q <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            step         <= '0;
            drain_cnt    <= '0;
            tile_idx     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_RESTART;
                        busy         <= 1'b1;
                        pe_restart_q <= 1'b1;
                        step         <= '0;
                    end
                end

                S_RESTART: begin
                    pe_restart_q <= 1'b0;
                    state        <= S_STREAM;
                    rd_en        <= 1'b1;
                    rd_addr      <= tile_base;
                    step         <= '0;
                end

                S_STREAM: begin
                    if (step == LAST_STEP) begin
                        state     <= S_DRAIN;
                        rd_en     <= 1'b0;
                        rd_addr   <= '0;
                        drain_cnt <= '0;
                    end else begin
                        step    <= step + STEP_W'(1);
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end

                S_DRAIN: begin
                    if (drain_cnt == DRAIN_END) begin
                        state     <= S_WAIT_OFM;
                        ofm_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DCNT_W'(1);
                    end
                end

                S_WAIT_OFM: begin
                    if (ofm_ready) begin
                        ofm_valid <= 1'b0;
                        if (tile_idx < LAST_TILE) begin
                            tile_idx     <= tile_idx + TILE_W'(1);
                            state        <= S_RESTART;
                            pe_restart_q <= 1'b1;
                            step         <= '0;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    // tile_idx returns to 0 only here, never by overflow.
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    tile_idx <= '0;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Operand stage. Buffer data arrives one cycle after the strobe and is
    // registered onto the PE buses. Cycles without returned data present a
    // zero weight and hold IFM, so the PE accumulators see a zero product.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            Weight   <= 8'h00;
            IFM      <= '0;
        end else begin
            rd_valid <= rd_en;
            Weight   <= rd_valid ? wgt_rd_data : 8'h00;
            if (rd_valid) begin
                IFM <= ifm_rd_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    a_step_bound: assert property (@(posedge clk) disable iff (!reset_n)
        step <= LAST_STEP);

    a_restart_zero_weight: assert property (@(posedge clk) disable iff (!reset_n)
        pe_restart_q |-> (Weight == 8'h00));

    a_read_only_streaming: assert property (@(posedge clk) disable iff (!reset_n)
        rd_en |-> (state == S_STREAM));

endmodule

// File: tb/tb_conv_feed_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_conv_feed_ctrl
//
// Bench for conv_feed_ctrl with default parameters. A timeline model derives
// every expected output from the cycle offset inside the current tile
// (restart at offset 0, reads at 1..27, weights at 3..29, ofm_valid from 32
// until accepted). A PE-0 accumulator checks the end-to-end dot product per
// tile, and directed scenarios pin absolute cycle numbers by hand.
// -----------------------------------------------------------------------------
module tb_conv_feed_ctrl;

    localparam int NUM_OF_PE  = 256;
    localparam int KERNEL_PIX = 9;
    localparam int NUM_CH     = 3;
    localparam int NUM_TILES  = 4;
    localparam int DRAIN_LAT  = 3;
    localparam int STEPS      = NUM_CH * KERNEL_PIX;
    localparam int ADDR_W     = 7;
    localparam int TILE_W     = 2;
    localparam int W          = NUM_OF_PE * 8;
    localparam int VALID_OFS  = 1 + STEPS + 1 + DRAIN_LAT;   // 32

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              busy;
    logic              done;
    logic              ifm_rd_en;
    logic [ADDR_W-1:0] ifm_rd_addr;
    logic [W-1:0]      ifm_rd_data;
    logic              wgt_rd_en;
    logic [ADDR_W-1:0] wgt_rd_addr;
    logic [7:0]        wgt_rd_data;
    logic [W-1:0]      IFM;
    logic [7:0]        Weight;
    logic [NUM_OF_PE-1:0] PE_restart;
    logic              ofm_valid;
    logic              ofm_ready;
    logic [TILE_W-1:0] tile_idx;

    conv_feed_ctrl #(
        .NUM_OF_PE (NUM_OF_PE),
        .KERNEL_PIX(KERNEL_PIX),
        .NUM_CH    (NUM_CH),
        .NUM_TILES (NUM_TILES),
        .DRAIN_LAT (DRAIN_LAT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .ifm_rd_en  (ifm_rd_en),
        .ifm_rd_addr(ifm_rd_addr),
        .ifm_rd_data(ifm_rd_data),
        .wgt_rd_en  (wgt_rd_en),
        .wgt_rd_addr(wgt_rd_addr),
        .wgt_rd_data(wgt_rd_data),
        .IFM        (IFM),
        .Weight     (Weight),
        .PE_restart (PE_restart),
        .ofm_valid  (ofm_valid),
        .ofm_ready  (ofm_ready),
        .tile_idx   (tile_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, cyc, act, act, exp, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got low64 %h, expected low64 %h",
                     name, cyc, act[63:0], exp[63:0]);
        end
    endtask

    // Buffer contents: weight byte at a is a; IFM word mixes address and PE.
    function automatic logic [7:0] wgt_byte(input int a);
        return 8'(a);
    endfunction

    function automatic logic [W-1:0] ifm_word(input int a);
        logic [W-1:0] w;
        for (int p = 0; p < NUM_OF_PE; p++) w[p*8 +: 8] = 8'(a * 7 + p * 13 + 1);
        return w;
    endfunction

    function automatic longint tile_sum(input int k);
        longint s = 0;
        for (int i = 0; i < STEPS; i++) begin
            logic [W-1:0] wd;
            wd = ifm_word(k * STEPS + i);
            s += longint'(wgt_byte(k * STEPS + i)) * longint'(wd[7:0]);
        end
        return s;
    endfunction

    // Buffers: one-cycle read latency, junk when not read.
    always @(posedge clk) begin
        if (ifm_rd_en) ifm_rd_data <= ifm_word(int'(ifm_rd_addr));
        else           ifm_rd_data <= {NUM_OF_PE{8'hEE}};
        if (wgt_rd_en) wgt_rd_data <= wgt_byte(int'(wgt_rd_addr));
        else           wgt_rd_data <= 8'hEE;
    end

    // ---------------- model + compare (negedge) ----------------
    bit           m_active;
    int           m_r;          // restart cycle of current tile
    int           m_k;          // current tile
    int           m_done_cyc;
    logic [W-1:0] m_ifm;
    longint       acc;

    // Observation records for the literal checks.
    int restart_q[$];
    int done_q[$];
    int hs_q[$];
    int first_rd_cyc, first_rd_addr, addr63_cyc, w26_cyc;
    int valid_cnt[NUM_TILES];

    task automatic clear_rec();
        restart_q.delete(); done_q.delete(); hs_q.delete();
        first_rd_cyc = -1; first_rd_addr = -1; addr63_cyc = -1; w26_cyc = -1;
        for (int i = 0; i < NUM_TILES; i++) valid_cnt[i] = 0;
    endtask

    initial begin
        m_active = 0; m_done_cyc = -1; m_ifm = '0; m_r = 0; m_k = 0; acc = 0;
        clear_rec();
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_rd_en", {ifm_rd_en, wgt_rd_en}, 0);
            check("rst_addr", {ifm_rd_addr, wgt_rd_addr}, 0);
            check("rst_weight", Weight, 0);
            check_wide("rst_ifm", IFM, '0);
            check("rst_pe_restart", (PE_restart == '0), 1);
            check("rst_ofm_valid", ofm_valid, 0);
            check("rst_tile_idx", tile_idx, 0);
            m_active = 0; m_done_cyc = -1; m_ifm = '0;
        end else begin
            bit e_busy, e_done, e_rst, e_rd, e_valid;
            int e_tile, e_addr, d;
            logic [7:0] e_w;
            e_busy = 0; e_done = 0; e_rst = 0; e_rd = 0; e_valid = 0;
            e_tile = 0; e_addr = 0; e_w = 8'h00; d = 0;
            if (m_active && m_done_cyc == cyc) begin
                e_busy = 1; e_done = 1; e_tile = NUM_TILES - 1;
            end else if (m_active) begin
                d      = cyc - m_r;
                e_busy = 1;
                e_tile = m_k;
                e_rst  = (d == 0);
                e_rd   = (d >= 1 && d <= STEPS);
                e_addr = m_k * STEPS + d - 1;
                if (d >= 3 && d <= STEPS + 2) begin
                    e_w   = wgt_byte(m_k * STEPS + d - 3);
                    m_ifm = ifm_word(m_k * STEPS + d - 3);
                end
                e_valid = (d >= VALID_OFS);
            end
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check_wide("pe_restart", W'(PE_restart), e_rst ? W'({NUM_OF_PE{1'b1}}) : '0);
            check("ifm_rd_en", ifm_rd_en, e_rd);
            check("wgt_rd_en", wgt_rd_en, e_rd);
            if (e_rd) begin
                check("ifm_rd_addr", ifm_rd_addr, e_addr);
                check("wgt_rd_addr", wgt_rd_addr, e_addr);
            end
            check("weight", Weight, e_w);
            check_wide("ifm", IFM, m_ifm);
            check("ofm_valid", ofm_valid, e_valid);
            check("tile_idx", tile_idx, e_tile);

            // PE-0 accumulator over the DUT's operand buses.
            if (PE_restart[0]) acc = 0;
            else acc += longint'(Weight) * longint'(IFM[7:0]);
            if (m_active && m_done_cyc < 0 && d == VALID_OFS)
                check("pe0_dot_product", acc, tile_sum(m_k));

            // Records.
            if (PE_restart[0]) restart_q.push_back(cyc);
            if (done) done_q.push_back(cyc);
            if (ofm_valid && ofm_ready) hs_q.push_back(cyc);
            if (ofm_valid) valid_cnt[tile_idx]++;
            if (wgt_rd_en && first_rd_cyc < 0) begin
                first_rd_cyc = cyc; first_rd_addr = int'(wgt_rd_addr);
            end
            if (wgt_rd_en && wgt_rd_addr == 7'd63 && addr63_cyc < 0) addr63_cyc = cyc;
            if (Weight == 8'd26 && w26_cyc < 0) w26_cyc = cyc;

            // Advance the model with this cycle's inputs.
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_r = cyc + 1; m_k = 0; m_done_cyc = -1;
                end
            end else if (m_done_cyc == cyc) begin
                m_active = 0;
            end else if (m_done_cyc < 0 && (cyc - m_r) >= VALID_OFS && ofm_ready) begin
                if (m_k < NUM_TILES - 1) begin
                    m_k++; m_r = cyc + 1;
                end else begin
                    m_done_cyc = cyc + 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic bit cond(input int which);
        case (which)
            0: return done;
            1: return ofm_valid;
            2: return wgt_rd_en;
            3: return ofm_valid && ofm_ready && (tile_idx == TILE_W'(NUM_TILES - 1));
            4: return wgt_rd_en && (wgt_rd_addr == 7'd40) && (tile_idx == 2'd1);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (!cond(which) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, cond(which), 1);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(output int s0);
        settle();
        start = 1'b1;
        s0    = cyc;
        settle();
        start = 1'b0;
    endtask

    int s0;

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        ofm_ready = 1'b1;
        repeat (3) settle();
        check("reset_busy", busy, 0);
        check("reset_weight", Weight, 0);
        reset_n = 1'b1;
        repeat (2) settle();

        // A: single map, ofm_ready held high.
        clear_rec();
        pulse_start(s0);
        wait_for(0, 300, "wait_done_A");
        settle();
        check("A_restart0_cycle", restart_q.size() > 0 ? restart_q[0] - s0 : -1, 1);
        check("A_restart1_cycle", restart_q.size() > 1 ? restart_q[1] - s0 : -1, 34);
        check("A_first_read_cycle", first_rd_cyc - s0, 2);
        check("A_first_read_addr", first_rd_addr, 0);
        check("A_weight26_cycle", w26_cyc - s0, 30);
        check("A_addr63_cycle", addr63_cyc - s0, 77);
        check("A_done_cycle", done_q.size() > 0 ? done_q[0] - s0 : -1, 133);
        check("A_valid_cycles_t3", valid_cnt[3], 1);
        check("A_busy_after_done", busy, 0);

        // B: back-pressure on tile 0 for 10 cycles.
        repeat (2) settle();
        clear_rec();
        ofm_ready = 1'b0;
        pulse_start(s0);
        wait_for(1, 100, "wait_valid_B");
        repeat (10) @(posedge clk);
        #1 ofm_ready = 1'b1;
        wait_for(0, 300, "wait_done_B");
        settle();
        check("B_valid_cycles_t0", valid_cnt[0], 11);
        check("B_valid_cycles_t1", valid_cnt[1], 1);
        check("B_restart_after_accept",
              (restart_q.size() > 1 && hs_q.size() > 0) ? restart_q[1] - hs_q[0] : -1, 1);
        check("B_done_cycle", done_q.size() > 0 ? done_q[0] - s0 : -1, 143);

        // C: start pulsed during STREAM and during DONE.
        repeat (2) settle();
        clear_rec();
        pulse_start(s0);
        wait_for(2, 50, "wait_stream_C");
        settle();
        start = 1'b1;
        settle();
        start = 1'b0;
        wait_for(3, 300, "wait_last_hs_C");
        settle();
        start = 1'b1;
        check("C_done_at_second_start", done, 1);
        settle();
        start = 1'b0;
        repeat (5) settle();
        check("C_single_done", done_q.size(), 1);
        check("C_idle_after", busy, 0);

        // D: reset at step 13 of tile 1, then a clean restart.
        clear_rec();
        pulse_start(s0);
        wait_for(4, 100, "wait_step13_t1_D");
        #1 reset_n = 1'b0;
        #1;
        check("D_async_busy", busy, 0);
        check("D_async_rd_en", wgt_rd_en, 0);
        check("D_async_addr", wgt_rd_addr, 0);
        check("D_async_tile", tile_idx, 0);
        check_wide("D_async_ifm", IFM, '0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) settle();
        check("D_no_done_after_reset", done_q.size(), 0);
        clear_rec();
        pulse_start(s0);
        wait_for(0, 300, "wait_done_D");
        settle();
        check("D_first_addr", first_rd_addr, 0);
        check("D_restart_cycle", restart_q.size() > 0 ? restart_q[0] - s0 : -1, 1);
        check("D_done_cycle", done_q.size() > 0 ? done_q[0] - s0 : -1, 133);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_feed_ctrl.md
CONV_FEED_CTRL -- requirements
Module: conv_feed_ctrl

Interface
REQ-001 Parameter NUM_OF_PE, 256: number of PEs in the downstream CONV_256PE array.
REQ-002 Parameter KERNEL_PIX, 9: weights per kernel channel (3x3).
REQ-003 Parameter NUM_CH, 3: input channels per output pixel.
REQ-004 Parameter NUM_TILES, 4: tiles per feature map (32x32 / NUM_OF_PE).
REQ-005 Parameter DRAIN_LAT, 3: cycles from the last nonzero weight at the PE input until the PE result is stable.
REQ-006 Port list (ADDR_W = clog2(NUM_TILES*NUM_CH*KERNEL_PIX)):
- clk, input, 1: sole clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle request to convolve a full feature map.
- busy, output, 1: high from start acceptance until done.
- done, output, 1: one-cycle pulse after the last tile is handed off.
- ifm_rd_en, output, 1: IFM buffer read strobe.
- ifm_rd_addr, output, ADDR_W: IFM buffer word address.
- ifm_rd_data, input, NUM_OF_PE*8: IFM word, valid the cycle after ifm_rd_en.
- wgt_rd_en, output, 1: weight buffer read strobe.
- wgt_rd_addr, output, ADDR_W: weight buffer byte address.
- wgt_rd_data, input, 8: weight byte, valid the cycle after wgt_rd_en.
- IFM, output, NUM_OF_PE*8: registered operand bus to the PE array.
- Weight, output, 8: registered broadcast weight to the PE array.
- PE_restart, output, NUM_OF_PE: all bits equal; clears the PE accumulators.
- ofm_valid, output, 1: the PE array OFM holds the result of tile tile_idx.
- ofm_ready, input, 1: the downstream stage accepts the tile result.
- tile_idx, output, clog2(NUM_TILES): index of the current tile.

Function
REQ-007 FSM states: IDLE, RESTART, STREAM, DRAIN, WAIT_OFM, DONE.
REQ-008 IDLE: start=1 -> RESTART and busy=1; start is ignored in every other state.
REQ-009 RESTART: lasts exactly 1 cycle with PE_restart all ones and the step counter cleared, then goes to STREAM.
REQ-010 STREAM issues one step per cycle for s = 0..NUM_CH*KERNEL_PIX-1 (27 steps), with ch = s/KERNEL_PIX and pix = s%KERNEL_PIX.
REQ-011 Step address, identical for both buffers: tile_idx*NUM_CH*KERNEL_PIX + ch*KERNEL_PIX + pix.
REQ-012 ifm_rd_en and wgt_rd_en are high only during STREAM cycles, both in the same cycle.
REQ-013 A read issued in cycle n returns data in cycle n+1, which is registered onto IFM/Weight and presented from cycle n+2 (2-cycle issue-to-PE latency).
REQ-014 Cycles in which no data is returned drive Weight to 8'h00 and hold IFM, so the PE accumulation is unaffected.
REQ-015 After the last step, STREAM -> DRAIN; DRAIN waits 1 + DRAIN_LAT cycles (register stage plus PE latency), then goes to WAIT_OFM.
REQ-016 WAIT_OFM: ofm_valid=1 until a cycle with ofm_ready=1; that cycle ends the handshake, and ofm_valid drops on the next edge.
REQ-017 On handshake, if tile_idx < NUM_TILES-1: tile_idx increments and the FSM goes to RESTART; otherwise it goes to DONE.
REQ-018 If ofm_ready is already high on WAIT_OFM entry, ofm_valid is high for exactly 1 cycle.
REQ-019 DONE: lasts 1 cycle with done=1, clears tile_idx to 0, then returns to IDLE with busy=0 in the same transition.
REQ-020 A start arriving in the DONE cycle is ignored.
REQ-021 tile_idx wraps only through DONE, never by counter overflow.
REQ-022 PE_restart is never asserted in the same cycle as a nonzero Weight.
REQ-023 The step counter never exceeds NUM_CH*KERNEL_PIX-1.
REQ-024 Total cycles per map with ofm_ready held high: NUM_TILES*(1 + 27 + 1 + DRAIN_LAT + 1) + 1 = 133 for the default parameters.

Reset
REQ-025 reset_n=0 forces, asynchronously: FSM to IDLE, busy=0, done=0, ofm_valid=0, PE_restart=0, rd_en=0, rd addresses=0, IFM=0, Weight=0, tile_idx=0, step counter=0.
REQ-026 Reset asserted mid-operation abandons the map; after release the block waits in IDLE for a new start, with no done pulse.

Verification
REQ-027 Single map, ofm_ready=1, buffer word at address a = a: start at cycle 0 -> PE_restart at cycle 1; rd addresses 0..26 in cycles 2..28; Weight=0..26 in cycles 4..30; done at cycle 133.
REQ-028 Address coverage: tile 2 reads addresses 54..80, with ch=1, pix=0 at address 63.
REQ-029 Back-pressure: ofm_ready=0 for 10 cycles in tile 0 -> ofm_valid held for 11 cycles, no reads issued, tile 1 restart 1 cycle after the accept.
REQ-030 start pulsed during STREAM and again in DONE -> both ignored; exactly one done pulse per accepted start.
REQ-031 reset_n low at step 13 of tile 1 -> all outputs zero immediately; a new start then begins at tile 0, address 0.
REQ-032 Golden model: 3x3x3x1 convolution over a 32x32x3 map via the CONV_256PE model -> 1024 OFM bytes match the reference hex, and the Weight bus is 0 on every PE_restart cycle.
